// File: rtl/serial_addsub_pkg.sv
// serial_addsub_pkg: shared state encoding and sizing helper for the serial adder/subtractor
package serial_addsub_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/addsub_slice.sv
// addsub_slice: W-bit combinational ripple adder exposing the carry into its top bit
module addsub_slice #(
  parameter int W = 1
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         cmsb
);
  logic c;
  // ripple the carry LSB to MSB, remembering the carry entering the top bit
  always_comb begin
    c = cin;
    sum = '0;
    cmsb = cin;
    for (int i = 0; i < W; i++) begin
      cmsb = c;
      sum[i] = a[i] ^ b[i] ^ c;
      c = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    cout = c;
  end
endmodule

// File: rtl/serial_addsub.sv
// serial_addsub: multi-cycle LSB-first adder/subtractor; optional saturation via SERIAL_ADDSUB_SAT_EN
module serial_addsub
  import serial_addsub_pkg::*;
#(
  parameter int WIDTH          = 10,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             sub_i,
  input  logic             cin_i,
`ifdef SERIAL_ADDSUB_SAT_EN
  input  logic             sat_i,
`endif
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o,
  output logic             ovf_o,
  output logic             zero_o
);
  localparam int N  = WIDTH / BITS_PER_CYCLE;
  localparam int CW = cnt_w(N);
  localparam logic [WIDTH-1:0] MAXP = {1'b0, {(WIDTH-1){1'b1}}};
  if (WIDTH % BITS_PER_CYCLE != 0) begin : g_bad_bpc
    $error("serial_addsub: BITS_PER_CYCLE must divide WIDTH");
  end
  state_t                      state;
  logic [WIDTH-1:0]            a_q, b_q, r_q, r_nxt, res;
  logic [WIDTH+BITS_PER_CYCLE-1:0] sh;
  logic [BITS_PER_CYCLE-1:0]   s;
  logic [CW-1:0]               cnt;
  logic                        c_q, sat_q, sat_in, co, cm, ovf, last;
`ifdef SERIAL_ADDSUB_SAT_EN
  assign sat_in = sat_i;
`else
  assign sat_in = 1'b0;
`endif
  addsub_slice #(.W(BITS_PER_CYCLE)) u_slice (
    .a(a_q[BITS_PER_CYCLE-1:0]),
    .b(b_q[BITS_PER_CYCLE-1:0]),
    .cin(c_q),
    .sum(s),
    .cout(co),
    .cmsb(cm)
  );
  // new slice bits enter from the MSB side; on the last beat this is the full word
  always_comb begin
    sh = {s, r_q};
    r_nxt = sh[WIDTH+BITS_PER_CYCLE-1:BITS_PER_CYCLE];
    last = cnt == CW'(N - 1);
    ovf = co ^ cm;
    res = (sat_q && ovf) ? (r_nxt[WIDTH-1] ? MAXP : ~MAXP) : r_nxt;
  end
  // control FSM with operand/result shift registers and registered flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      a_q <= '0;
      b_q <= '0;
      r_q <= '0;
      c_q <= 1'b0;
      sat_q <= 1'b0;
      cnt <= '0;
      busy_o <= 1'b0;
      done_o <= 1'b0;
      sum_o <= '0;
      cout_o <= 1'b0;
      ovf_o <= 1'b0;
      zero_o <= 1'b1;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: if (start_i) begin
          a_q <= a_i;
          b_q <= sub_i ? ~b_i : b_i;
          c_q <= sub_i ^ cin_i;
          sat_q <= sat_in;
          r_q <= '0;
          cnt <= '0;
          busy_o <= 1'b1;
          state <= RUN;
        end
        RUN: begin
          a_q <= a_q >> BITS_PER_CYCLE;
          b_q <= b_q >> BITS_PER_CYCLE;
          c_q <= co;
          r_q <= r_nxt;
          cnt <= cnt + CW'(1);
          if (last) begin
            state <= DONE;
            done_o <= 1'b1;
            sum_o <= res;
            cout_o <= co;
            ovf_o <= ovf;
            zero_o <= res == '0;
          end
        end
        DONE: begin
          busy_o <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy_o <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_serial_addsub.sv
// tb_serial_addsub: scoreboard bench for BPC=1 and BPC=5 instances
module tb_serial_addsub;
  logic clk = 1'b0, rst_n = 1'b0, st1 = 1'b0, st5 = 1'b0, sub = 1'b0, cin = 1'b0;
  logic [9:0] a = '0, b = '0;
`ifdef SERIAL_ADDSUB_SAT_EN
  logic sat = 1'b0;
`endif
  logic busy1, done1, cout1, ovf1, zero1, busy5, done5, cout5, ovf5, zero5;
  logic [9:0] sum1, sum5;
  int cyc = 0, checks = 0, errors = 0;
  typedef struct {logic [9:0] s; logic c, v, z; int t;} exp_t;
  exp_t q1[$], q5[$];
  exp_t e1, e5;

  serial_addsub #(.WIDTH(10), .BITS_PER_CYCLE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start_i(st1), .sub_i(sub), .cin_i(cin),
`ifdef SERIAL_ADDSUB_SAT_EN
    .sat_i(sat),
`endif
    .a_i(a), .b_i(b), .busy_o(busy1), .done_o(done1), .sum_o(sum1),
    .cout_o(cout1), .ovf_o(ovf1), .zero_o(zero1));
  serial_addsub #(.WIDTH(10), .BITS_PER_CYCLE(5)) dut5 (
    .clk(clk), .rst_n(rst_n), .start_i(st5), .sub_i(sub), .cin_i(cin),
`ifdef SERIAL_ADDSUB_SAT_EN
    .sat_i(sat),
`endif
    .a_i(a), .b_i(b), .busy_o(busy5), .done_o(done5), .sum_o(sum5),
    .cout_o(cout5), .ovf_o(ovf5), .zero_o(zero5));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) if (done1 === 1'b1) begin
    if (q1.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL d1_spurious_done actual=1 required=0 (cycle %0d)", cyc);
    end else begin
      e1 = q1.pop_front();
      chk("d1_sum", 32'(sum1), 32'(e1.s));
      chk("d1_cout", 32'(cout1), 32'(e1.c));
      chk("d1_ovf", 32'(ovf1), 32'(e1.v));
      chk("d1_zero", 32'(zero1), 32'(e1.z));
      chk("d1_latency", cyc, e1.t);
    end
  end

  always @(negedge clk) if (done5 === 1'b1) begin
    if (q5.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL d5_spurious_done actual=1 required=0 (cycle %0d)", cyc);
    end else begin
      e5 = q5.pop_front();
      chk("d5_sum", 32'(sum5), 32'(e5.s));
      chk("d5_cout", 32'(cout5), 32'(e5.c));
      chk("d5_ovf", 32'(ovf5), 32'(e5.v));
      chk("d5_zero", 32'(zero5), 32'(e5.z));
      chk("d5_latency", cyc, e5.t);
    end
  end

  task automatic push(input int d, input logic [9:0] es, input logic ec, input logic ev, input int t);
    exp_t e;
    e.s = es;
    e.c = ec;
    e.v = ev;
    e.z = es == 10'd0;
    e.t = t;
    if (d != 0) q5.push_back(e);
    else q1.push_back(e);
  endtask

  task automatic go(input int d, input logic s, input logic ci, input logic [9:0] aa, input logic [9:0] bb,
                    input logic st, input logic [9:0] es, input logic ec, input logic ev);
    int n;
    n = (d != 0) ? 2 : 10;
    @(negedge clk);
    sub = s;
    cin = ci;
    a = aa;
    b = bb;
`ifdef SERIAL_ADDSUB_SAT_EN
    sat = st;
`else
    if (st) $display("note: saturation requested without SERIAL_ADDSUB_SAT_EN");
`endif
    if (d != 0) st5 = 1'b1;
    else st1 = 1'b1;
    push(d, es, ec, ev, cyc + 1 + n);
    @(negedge clk);
    st1 = 1'b0;
    st5 = 1'b0;
    chk((d != 0) ? "d5_busy" : "d1_busy", 32'((d != 0) ? busy5 : busy1), 32'd1);
    repeat (n + 2) @(negedge clk);
`ifdef SERIAL_ADDSUB_SAT_EN
    sat = 1'b0;
`endif
  endtask

  task automatic chk_reset();
    chk("rst_busy", 32'(busy1), 32'd0);
    chk("rst_done", 32'(done1), 32'd0);
    chk("rst_sum", 32'(sum1), 32'd0);
    chk("rst_cout", 32'(cout1), 32'd0);
    chk("rst_ovf", 32'(ovf1), 32'd0);
    chk("rst_zero", 32'(zero1), 32'd1);
    chk("rst_busy5", 32'(busy5), 32'd0);
    chk("rst_sum5", 32'(sum5), 32'd0);
  endtask

  initial begin
    int c;
    repeat (3) @(negedge clk);
    chk_reset();
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    go(0, 0, 0, 10'd300, 10'd200, 0, 10'd500, 0, 0);
    go(0, 0, 0, 10'd1023, 10'd1, 0, 10'd0, 1, 0);
    go(0, 0, 0, 10'd511, 10'd1, 0, 10'h200, 0, 1);
    go(0, 1, 0, 10'd5, 10'd7, 0, 10'h3FE, 0, 0);
    go(0, 1, 0, 10'd7, 10'd5, 0, 10'd2, 1, 0);
    go(0, 1, 1, 10'd7, 10'd5, 0, 10'd1, 1, 0);
`ifdef SERIAL_ADDSUB_SAT_EN
    go(0, 0, 0, 10'd511, 10'd1, 1, 10'd511, 0, 1);
    go(0, 1, 0, 10'h200, 10'd1, 1, 10'h200, 1, 1);
    go(1, 0, 0, 10'd511, 10'd1, 1, 10'd511, 0, 1);
`endif
    go(1, 0, 0, 10'd1023, 10'd1, 0, 10'd0, 1, 0);
    go(1, 0, 0, 10'd300, 10'd200, 0, 10'd500, 0, 0);
    go(1, 1, 0, 10'd5, 10'd7, 0, 10'h3FE, 0, 0);
    // start pulsed mid-run with new operands must be ignored
    @(negedge clk);
    sub = 1'b0;
    cin = 1'b0;
    a = 10'd300;
    b = 10'd200;
    st1 = 1'b1;
    push(0, 10'd500, 0, 0, cyc + 11);
    @(negedge clk);
    st1 = 1'b0;
    repeat (3) @(negedge clk);
    a = 10'd7;
    b = 10'd1;
    sub = 1'b1;
    cin = 1'b1;
    st1 = 1'b1;
    @(negedge clk);
    st1 = 1'b0;
    repeat (10) @(negedge clk);
    // asynchronous reset at beat 4 aborts the operation
    sub = 1'b1;
    cin = 1'b0;
    a = 10'd7;
    b = 10'd5;
    st1 = 1'b1;
    @(negedge clk);
    st1 = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_reset();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    go(0, 1, 1, 10'd7, 10'd5, 0, 10'd1, 1, 0);
    // held start on the 2-beat instance: one result every 4 cycles
    @(negedge clk);
    sub = 1'b0;
    cin = 1'b0;
    a = 10'd1023;
    b = 10'd1;
    st5 = 1'b1;
    c = cyc;
    push(1, 10'd0, 1, 0, c + 3);
    push(1, 10'd0, 1, 0, c + 7);
    push(1, 10'd0, 1, 0, c + 11);
    repeat (11) @(negedge clk);
    st5 = 1'b0;
    repeat (8) @(negedge clk);
    chk("d1_missing_done", 32'(q1.size()), 32'd0);
    chk("d5_missing_done", 32'(q5.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/serial_addsub.md
Name: serial_addsub

Overview:
- Parametrised, multi-cycle adder/subtractor for the CPU datapath.
- Processes BITS_PER_CYCLE operand bits per clock, LSB first, through a ripple slice. The carry is held in a flop between cycles.
- Uses a start/busy/done handshake and produces carry, signed-overflow and zero flags.
- Sits between the register file read ports and the ALU result mux. Trades area for latency on WIDTH-bit operands.

Parameters:
- WIDTH, 10, operand and result width in bits.
- BITS_PER_CYCLE, 1, bits resolved per clock. Must divide WIDTH exactly; elaboration error otherwise.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start_i  input  1  request. Accepted only in IDLE.
- sub_i  input  1  0 = A+B+cin_i, 1 = A-B-cin_i (cin_i acts as borrow-in). Sampled with start_i.
- cin_i  input  1  carry/borrow in. Sampled with start_i.
- a_i  input  WIDTH  operand A. Sampled with start_i.
- b_i  input  WIDTH  operand B. Sampled with start_i.
- busy_o  output  1  high in RUN and DONE.
- done_o  output  1  one-cycle pulse when the result is valid.
- sum_o  output  WIDTH  result. Holds until the next accept.
- cout_o  output  1  add: carry-out. Sub: 1 = no borrow (A >= B+cin_i, unsigned).
- ovf_o  output  1  two's-complement signed overflow.
- zero_o  output  1  sum_o == 0.

Behaviour:
- Reset state: state=IDLE; busy_o=0, done_o=0, sum_o=0, cout_o=0, ovf_o=0, zero_o=1. All internal registers clear.
- Reset is asynchronous. Asserting it mid-operation aborts immediately and returns to IDLE with reset values; there is no partial result.
- Definitions:
  - N = WIDTH/BITS_PER_CYCLE.
  - Effective B = sub ? ~b : b.
  - Effective carry-in = sub ? ~cin_i : cin_i.
- IDLE:
  - On start_i=1, latch A, effective B and carry-in into shift registers, clear the beat counter, go to RUN.
  - sum_o and the flags keep their previous values.
- RUN:
  - Each edge: slice adds the low BITS_PER_CYCLE bits of A and B plus the carry flop.
  - Result bits shift into the result register from the MSB side. A and B shift right by BITS_PER_CYCLE. Carry flop updates.
  - Counter increments. On the beat with counter == N-1, go to DONE.
  - On that same edge, commit sum_o, cout_o and zero_o.
  - ovf_o = carry into MSB XOR carry out of MSB. Capture the MSB carry-in on the final beat.
- DONE: done_o=1 for exactly this cycle, then unconditionally return to IDLE.
- Latency: accept edge at t0 puts done_o high during the cycle following edge t0+N. Minimum issue interval is N+2 cycles; start_i may be held high for back-to-back operations.
- start_i in RUN or DONE is ignored. No queueing, no error flag.
- Operands changing after accept have no effect.
- Width rule: all arithmetic is modulo 2^WIDTH. Carry out of the top bit goes only to cout_o.

Optional Feature:
- Macro SERIAL_ADDSUB_SAT_EN.
- Defined:
  - Extra port sat_i (input, 1), sampled with start_i.
  - When sat_i=1 and signed overflow occurs, sum_o is clamped at commit: 2^(WIDTH-1)-1 if the true result is positive, -2^(WIDTH-1) if negative.
  - ovf_o still reports 1.
  - zero_o is computed from the clamped value.
  - cout_o is unaffected.
- Undefined: no sat_i port; results always wrap.

Decomposition:
- Package serial_addsub_pkg:
  - State enum typedef (IDLE, RUN, DONE), 2-bit encoding.
  - Function computing counter width, clog2 of N, minimum 1.
- Sub-module addsub_slice: combinational BITS_PER_CYCLE-wide ripple adder.
  - Inputs: a, b, cin.
  - Outputs: sum, cout, and carry into its top bit (for ovf).
  - Instantiated once.
- State register, counter, shift registers and flag logic stay in serial_addsub.

Test Plan:
- WIDTH=10, BPC=1, add 300+200, cin 0 → done_o pulses 10 cycles after accept edge; sum 500, cout 0, ovf 0, zero 0.
- Add 1023+1 → sum 0, cout 1, ovf 0, zero 1.
- Add 511+1 → sum 512 (0x200), ovf 1, cout 0.
  - With SAT_EN and sat_i=1 → sum 511, ovf 1.
  - Sub 0x200-1 with sat_i=1 → sum 0x200, ovf 1.
- Sub 5-7, cin 0 → sum 1022 (0x3FE), cout 0, ovf 0.
  - Sub 7-5 → sum 2, cout 1.
  - Sub 7-5 with cin 1 → sum 1.
- start_i pulsed mid-RUN with new operands → ignored; original result returned.
  - rst_n low at beat 4 → outputs at reset values immediately; next start completes normally.
- BPC=5 → 1023+1 completes with done_o 2 cycles after accept, same results as the 1023+1 case.
  - Held start_i → exactly one done_o per N+2 cycles.
